frame_burst_read_gen: RTL



---
 rtl/frame_read_pkg.sv | 26 ++
 rtl/burst_credit_cnt.sv | 47 ++++
 rtl/frame_burst_read_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_read_pkg.sv
// Shared types and helpers for the frame burst read generator.
package frame_read_pkg;

    // Command FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Ceiling log2, clamped to at least 1 bit so every counter has a width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // The length field carries burst length minus one.
    function automatic int cmd_len_value(input int burst_len);
        return burst_len - 1;
    endfunction

endpackage

// File: rtl/burst_credit_cnt.sv
// Outstanding-burst counter: +1 per accepted command, -1 per completed burst.
// A completion with nothing outstanding is dropped; the count saturates at MAX_OUT.
module burst_credit_cnt
    import frame_read_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic can_issue,
    output logic empty
);

    localparam int CW = clog2(MAX_OUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          dec_eff;

    // Next count; simultaneous accept and completion cancel out.
    always_comb begin
        dec_eff = dec && (cnt_q != '0);
        cnt_d   = cnt_q;
        if (inc && !dec_eff) begin
            if (cnt_q != CW'(MAX_OUT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec_eff && !inc) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign can_issue = (cnt_q < CW'(MAX_OUT));
    assign empty     = (cnt_q == '0);

endmodule

// File: rtl/frame_burst_read_gen.sv
// Frame burst read generator: on each read_vs rising edge, walks the frame
// buffer from read_base and issues fixed-length burst read commands.
// Handshake: a command transfers on a cycle where cmd_valid & cmd_ready;
// once cmd_valid rises, cmd_valid and cmd_addr hold until that transfer.
// Optional feature macro: FRAME_ERR_CNT_EN adds the abort_cnt output.
module frame_burst_read_gen
    import frame_read_pkg::*;
#(
    parameter int ADDR_BITS   = 25,
    parameter int BURST_LEN   = 64,
    parameter int LEN_BITS    = 8,
    parameter int LINE_BURSTS = 30,
    parameter int LINES       = 1080,
    parameter int MAX_OUT     = 4
) (
    input  logic                 read_clk,
    input  logic                 read_rst_n,
    input  logic                 enable,
    input  logic                 read_vs,
    input  logic [ADDR_BITS-1:0] read_base,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 burst_done,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [1:0]           dbg_state
`ifdef FRAME_ERR_CNT_EN
    ,
    output logic [15:0]          abort_cnt
`endif
);

    localparam int BW = clog2(LINE_BURSTS);
    localparam int LW = clog2(LINES);
    localparam logic [LEN_BITS-1:0] CMD_LEN = LEN_BITS'(cmd_len_value(BURST_LEN));

    state_t                 state_q, state_d;
    logic                   vs_d_q;
    logic                   edge_q, edge_d;
    logic [ADDR_BITS-1:0]   cmd_addr_q, cmd_addr_d;
    logic [ADDR_BITS-1:0]   next_base_q, next_base_d;
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic [LW-1:0]          line_cnt_q, line_cnt_d;
    logic                   restart_q, restart_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   can_issue;
    logic                   credit_empty;
    logic                   hs;
    logic                   last_burst;

    burst_credit_cnt #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .inc       (hs),
        .dec       (burst_done),
        .can_issue (can_issue),
        .empty     (credit_empty)
    );

    // Commands are offered only in ISSUE with a free credit; the count only
    // rises on an accept, so an offered command cannot be withdrawn.
    assign cmd_valid  = (state_q == ISSUE) && can_issue;
    assign hs         = cmd_valid && cmd_ready;
    assign last_burst = hs && (burst_cnt_q == BW'(LINE_BURSTS - 1))
                           && (line_cnt_q == LW'(LINES - 1));

    // Next-state, address walk, counters and status pulses.
    always_comb begin
        state_d       = state_q;
        edge_d        = read_vs && !vs_d_q;
        cmd_addr_d    = cmd_addr_q;
        next_base_d   = next_base_q;
        burst_cnt_d   = burst_cnt_q;
        line_cnt_d    = line_cnt_q;
        restart_d     = restart_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_q && enable) begin
                    cmd_addr_d  = read_base;
                    burst_cnt_d = '0;
                    line_cnt_d  = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    cmd_addr_d = cmd_addr_q + ADDR_BITS'(BURST_LEN);
                    if (burst_cnt_q == BW'(LINE_BURSTS - 1)) begin
                        burst_cnt_d = '0;
                        line_cnt_d  = line_cnt_q + LW'(1);
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end
                if (edge_q) begin
                    next_base_d = read_base;
                    restart_d   = 1'b1;
                end
                // A pending command at restart still goes out before draining.
                if (last_burst || ((edge_q || restart_q) && (!cmd_valid || hs))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (edge_q) begin
                    next_base_d = read_base;
                    restart_d   = 1'b1;
                end
                if (credit_empty) begin
                    burst_cnt_d = '0;
                    line_cnt_d  = '0;
                    restart_d   = 1'b0;
                    if (restart_q) begin
                        frame_abort_d = 1'b1;
                        cmd_addr_d    = edge_q ? read_base : next_base_q;
                        state_d       = ISSUE;
                    end else begin
                        frame_done_d = 1'b1;
                        // A sync landing on the completion cycle starts the next frame.
                        if (edge_q && enable) begin
                            cmd_addr_d = read_base;
                            state_d    = ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            state_q       <= IDLE;
            vs_d_q        <= 1'b0;
            edge_q        <= 1'b0;
            cmd_addr_q    <= '0;
            next_base_q   <= '0;
            burst_cnt_q   <= '0;
            line_cnt_q    <= '0;
            restart_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_d_q        <= read_vs;
            edge_q        <= edge_d;
            cmd_addr_q    <= cmd_addr_d;
            next_base_q   <= next_base_d;
            burst_cnt_q   <= burst_cnt_d;
            line_cnt_q    <= line_cnt_d;
            restart_q     <= restart_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = CMD_LEN;
    assign busy        = (state_q != IDLE);
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign dbg_state   = state_q;

`ifdef FRAME_ERR_CNT_EN
    logic [15:0] abort_cnt_q, abort_cnt_d;

    // Saturating count of aborted frames.
    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (frame_abort_q && (abort_cnt_q != 16'hFFFF)) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
        end
    end

    // Abort counter register.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            abort_cnt_q <= 16'd0;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign abort_cnt = abort_cnt_q;
`endif

endmodule
